// File: rtl/csr_unit.sv
// ----------------------------------------------------------------------------
// csr_unit
//   Machine-mode CSR file for the rv32 core. Sits beside the execute stage:
//   the addressed CSR is read combinationally (pre-write value), and CSR
//   writes, trap entry and mret restore are applied on the rising clock edge.
//   Implements the ID registers, misa, mstatus (MIE/MPIE/MPP), mie, mip,
//   mtvec (direct/vectored), mcountinhibit, mscratch, mepc, mcause, mtval,
//   and the mcycle/minstret/mhpmcounterN counters with their user shadows.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   csr_op                0=none 1=RW 2=RS 3=RC
//   address, wrdata       CSR address and rs1/uimm operand
//   rd_data               current value of the addressed CSR
//   illegal               access invalid (only asserted while csr_op != 0)
//   trap, trap_cause,
//   trap_pc, trap_val     trap entry request and the state to record
//   mret                  return from trap
//   retire, hpm_event     counter increment sources
//   ext_eip/tip/sip       level interrupt sources, registered into mip
//   irq_pending           mstatus.MIE & |(mip & mie)
//   trap_vector           handler address for the current trap_cause
//   mepc_o                mret target
// ----------------------------------------------------------------------------
module csr_unit #(
    parameter logic [31:0] MHARTID   = 32'd0,
    parameter logic [31:0] MVENDORID = 32'd0,
    parameter logic [31:0] MARCHID   = 32'd0,
    parameter int          NUM_HPM   = 4,
    parameter int          CNT_W     = 64
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [1:0]                                csr_op,
    input  logic [11:0]                               address,
    input  logic [31:0]                               wrdata,
    output logic [31:0]                               rd_data,
    output logic                                      illegal,
    input  logic                                      trap,
    input  logic [31:0]                               trap_cause,
    input  logic [31:0]                               trap_pc,
    input  logic [31:0]                               trap_val,
    input  logic                                      mret,
    input  logic                                      retire,
    input  logic [((NUM_HPM > 0) ? NUM_HPM : 1)-1:0]  hpm_event,
    input  logic                                      ext_eip,
    input  logic                                      ext_tip,
    input  logic                                      ext_sip,
    output logic                                      irq_pending,
    output logic [31:0]                               trap_vector,
    output logic [31:0]                               mepc_o
);

    localparam int          HPM_N    = (NUM_HPM > 0) ? NUM_HPM : 1;
    localparam logic [31:0] MISA_VAL = 32'h4000_0100;
    localparam logic [31:0] MIE_MASK = 32'h0000_0888;
    // CY (bit 0), IR (bit 2) and one bit per implemented hpm counter from bit 3
    localparam logic [31:0] INH_MASK = 32'(((64'd1 << NUM_HPM) - 64'd1) << 3) | 32'h5;

    // Counter update: a CSR write to either half replaces the increment.
    function automatic logic [CNT_W-1:0] cnt_next(
        input logic [CNT_W-1:0] old,
        input logic             wr_lo,
        input logic             wr_hi,
        input logic             inc,
        input logic [31:0]      val
    );
        logic [63:0] v;
        v = 64'(old);
        if (wr_lo)
            v = {v[63:32], val};
        else if (wr_hi)
            v = {val, v[31:0]};
        else if (inc)
            v = v + 64'd1;
        return CNT_W'(v);
    endfunction

    logic              r_mst_mie;
    logic              r_mst_mpie;
    logic [1:0]        r_mst_mpp;
    logic [31:0]       r_mie;
    logic [31:0]       r_mip;
    logic [31:0]       r_mtvec;
    logic [31:0]       r_mepc;
    logic [31:0]       r_mcause;
    logic [31:0]       r_mtval;
    logic [31:0]       r_mscratch;
    logic [31:0]       r_mcountinhibit;
    logic [CNT_W-1:0]  r_mcycle;
    logic [CNT_W-1:0]  r_minstret;
    logic [CNT_W-1:0]  r_hpm [HPM_N];

    logic [31:0]       w_mstatus;
    logic              w_cnt_region;
    logic              w_cnt_hi;
    logic [4:0]        w_cnt_idx;
    logic              w_cnt_ok;
    logic              w_cnt_legal;
    logic [63:0]       w_cnt_val;
    logic              w_impl;
    logic [31:0]       w_rdata;
    logic [31:0]       w_wval;
    logic              w_do_write;
    logic              w_illegal;
    logic              w_we;
    logic              w_cnt_wr_lo;
    logic              w_cnt_wr_hi;
    logic [31:0]       w_base;

    assign w_mstatus = {19'd0, r_mst_mpp, 3'd0, r_mst_mpie, 3'd0, r_mst_mie, 3'd0};

    // Counter space: 0xB00-0xB1F / 0xB80-0xB9F and the 0xCxx user shadows
    assign w_cnt_region = ((address[11:8] == 4'hB) || (address[11:8] == 4'hC)) &&
                          (address[6:5] == 2'b00);
    assign w_cnt_hi     = address[7];
    assign w_cnt_idx    = address[4:0];

    always_comb begin
        w_cnt_ok  = 1'b0;
        w_cnt_val = 64'd0;
        if (w_cnt_idx == 5'd0) begin
            w_cnt_ok  = 1'b1;
            w_cnt_val = 64'(r_mcycle);
        end else if (w_cnt_idx == 5'd2) begin
            w_cnt_ok  = 1'b1;
            w_cnt_val = 64'(r_minstret);
        end
        for (int k = 0; k < NUM_HPM; k++) begin
            if (w_cnt_idx == 5'(k + 3)) begin
                w_cnt_ok  = 1'b1;
                w_cnt_val = 64'(r_hpm[k]);
            end
        end
    end

    assign w_cnt_legal = w_cnt_region && w_cnt_ok && (!w_cnt_hi || (CNT_W > 32));

    always_comb begin
        w_impl  = 1'b1;
        w_rdata = 32'd0;
        if (w_cnt_region) begin
            w_impl = w_cnt_legal;
            if (w_cnt_legal)
                w_rdata = w_cnt_hi ? w_cnt_val[63:32] : w_cnt_val[31:0];
        end else begin
            case (address)
                12'hF11: w_rdata = MVENDORID;
                12'hF12: w_rdata = MARCHID;
                12'hF14: w_rdata = MHARTID;
                12'h300: w_rdata = w_mstatus;
                12'h301: w_rdata = MISA_VAL;
                12'h304: w_rdata = r_mie;
                12'h305: w_rdata = r_mtvec;
                12'h320: w_rdata = r_mcountinhibit;
                12'h340: w_rdata = r_mscratch;
                12'h341: w_rdata = r_mepc;
                12'h342: w_rdata = r_mcause;
                12'h343: w_rdata = r_mtval;
                12'h344: w_rdata = r_mip;
                default: w_impl  = 1'b0;
            endcase
        end
    end

    always_comb begin
        case (csr_op)
            2'd1:    w_wval = wrdata;
            2'd2:    w_wval = w_rdata | wrdata;
            2'd3:    w_wval = w_rdata & ~wrdata;
            default: w_wval = w_rdata;
        endcase
    end

    // RS/RC with a zero operand are pure reads, so they may target read-only CSRs
    assign w_do_write  = (csr_op == 2'd1) || ((csr_op != 2'd0) && (wrdata != 32'd0));
    assign w_illegal   = (csr_op != 2'd0) &&
                         (!w_impl || ((address[11:10] == 2'b11) && w_do_write));
    // trap and mret both outrank a software write in the same cycle
    assign w_we        = w_do_write && !w_illegal && !trap && !mret;
    assign w_cnt_wr_lo = w_we && w_cnt_legal && !w_cnt_hi;
    assign w_cnt_wr_hi = w_we && w_cnt_legal && w_cnt_hi;

    assign rd_data     = w_rdata;
    assign illegal     = w_illegal;
    assign irq_pending = r_mst_mie & (|(r_mip & r_mie));
    assign mepc_o      = r_mepc;

    assign w_base      = {r_mtvec[31:2], 2'b00};
    assign trap_vector = ((r_mtvec[1:0] == 2'b01) && trap_cause[31]) ?
                         (w_base + {25'd0, trap_cause[4:0], 2'b00}) : w_base;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mst_mie       <= 1'b0;
            r_mst_mpie      <= 1'b0;
            r_mst_mpp       <= 2'b00;
            r_mie           <= 32'd0;
            r_mip           <= 32'd0;
            r_mtvec         <= 32'd0;
            r_mepc          <= 32'd0;
            r_mcause        <= 32'd0;
            r_mtval         <= 32'd0;
            r_mscratch      <= 32'd0;
            r_mcountinhibit <= 32'd0;
        end else begin
            // MEIP/MTIP/MSIP mirror the external levels, one cycle late
            r_mip <= {20'd0, ext_eip, 3'd0, ext_tip, 3'd0, ext_sip, 3'd0};
            if (trap) begin
                r_mepc     <= trap_pc & ~32'd3;
                r_mcause   <= trap_cause;
                r_mtval    <= trap_val;
                r_mst_mpie <= r_mst_mie;
                r_mst_mie  <= 1'b0;
                r_mst_mpp  <= 2'b11;
            end else if (mret) begin
                r_mst_mie  <= r_mst_mpie;
                r_mst_mpie <= 1'b1;
                r_mst_mpp  <= 2'b11;
            end else if (w_we) begin
                case (address)
                    12'h300: begin
                        // MPP only ever holds M, so software writes leave it alone
                        r_mst_mie  <= w_wval[3];
                        r_mst_mpie <= w_wval[7];
                    end
                    12'h304: r_mie           <= w_wval & MIE_MASK;
                    // Reserved MODE encodings collapse to direct mode
                    12'h305: r_mtvec         <= {w_wval[31:2], w_wval[1] ? 2'b00 : w_wval[1:0]};
                    12'h320: r_mcountinhibit <= w_wval & INH_MASK;
                    12'h340: r_mscratch      <= w_wval;
                    12'h341: r_mepc          <= w_wval & ~32'd3;
                    12'h342: r_mcause        <= w_wval;
                    12'h343: r_mtval         <= w_wval;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcycle   <= '0;
            r_minstret <= '0;
            for (int k = 0; k < HPM_N; k++)
                r_hpm[k] <= '0;
        end else begin
            r_mcycle   <= cnt_next(r_mcycle,
                                   w_cnt_wr_lo && (w_cnt_idx == 5'd0),
                                   w_cnt_wr_hi && (w_cnt_idx == 5'd0),
                                   !r_mcountinhibit[0], w_wval);
            r_minstret <= cnt_next(r_minstret,
                                   w_cnt_wr_lo && (w_cnt_idx == 5'd2),
                                   w_cnt_wr_hi && (w_cnt_idx == 5'd2),
                                   retire && !r_mcountinhibit[2], w_wval);
            for (int k = 0; k < NUM_HPM; k++) begin
                r_hpm[k] <= cnt_next(r_hpm[k],
                                     w_cnt_wr_lo && (w_cnt_idx == 5'(k + 3)),
                                     w_cnt_wr_hi && (w_cnt_idx == 5'(k + 3)),
                                     hpm_event[k] && !r_mcountinhibit[k + 3], w_wval);
            end
        end
    end

endmodule
